// File: rtl/vga_pkg.sv
// Shared timing constants, fetch FSM state type and line-address helper for the
// VGA line-buffer fetch path.
package vga_pkg;

    localparam int unsigned H_ADDR       = 640;
    localparam int unsigned V_ADDR       = 480;
    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned WPL          = H_ADDR / PIX_PER_WORD;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;

    // Word address of the first word of a display line; caller truncates.
    function automatic int unsigned line_base(input int unsigned fb_base,
                                              input int unsigned line,
                                              input int unsigned wpl);
        return fb_base + line * wpl;
    endfunction

endpackage

// File: rtl/vga_fetch_outq.sv
// Outstanding-read tracker and line-buffer write generation for returning read data.
module vga_fetch_outq
    import vga_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned OW      = $clog2(MAX_OUT + 1)
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          rd_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    input  logic          bank,
    output logic [OW-1:0] outstanding,
    output logic [7:0]    ret_cnt,
    output logic          lb_we,
    output logic          lb_bank,
    output logic [7:0]    lb_waddr,
    output logic [DW-1:0] lb_wdata
);

    logic [OW-1:0] out_q;
    logic [7:0]    ret_q;

    // Returns with nothing outstanding belong to a fetch abandoned by reset.
    always_comb begin
        lb_we    = mem_rvalid & (out_q != '0);
        lb_bank  = lb_we & bank;
        lb_waddr = lb_we ? ret_q : 8'd0;
        lb_wdata = lb_we ? mem_rdata : '0;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ret_q <= 8'd0;
        end else begin
            unique case ({rd_gnt, lb_we})
                2'b10:   out_q <= out_q + OW'(1);
                2'b01:   out_q <= out_q - OW'(1);
                default: out_q <= out_q;
            endcase
            if (clr) begin
                ret_q <= 8'd0;
            end else if (lb_we) begin
                ret_q <= ret_q + 8'd1;
            end
        end
    end

    assign outstanding = out_q;
    assign ret_cnt     = ret_q;

endmodule

// File: rtl/vga_fetch_ctrl.sv
// Line-buffer refill scheduler sharing one memory port with a low-priority pixel writer.
// Optional statistics outputs are built when VGA_FETCH_STATS_EN is defined.
module vga_fetch_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ADDR       = 640,
    parameter int unsigned V_ADDR       = 480,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned AW           = 18,
    parameter int unsigned DW           = 32,
    parameter int unsigned FB_BASE      = 0,
    parameter int unsigned MAX_OUT      = 4
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          de,
    input  logic          vsync,
    input  logic [9:0]    Y,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          lb_we,
    output logic          lb_bank,
    output logic [7:0]    lb_waddr,
    output logic [DW-1:0] lb_wdata,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    output logic          busy,
    output logic          underrun
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0]   stat_underrun,
    output logic [15:0]   stat_wr_stall
`endif
);

    localparam int unsigned WPL = H_ADDR / PIX_PER_WORD;
    localparam int unsigned OW  = $clog2(MAX_OUT + 1);

    fetch_state_e  state_q, state_d;
    logic          vsync_q, de_q, run_q, pend_q, underrun_q;
    logic [9:0]    y_q, line_q, pend_line_q, trig_line, start_line;
    logic [7:0]    issue_q, ret_cnt;
    logic [OW-1:0] outstanding;
    logic [AW-1:0] base;
    logic          vsync_rise, de_fall, trig, start, rd_gnt, busy_int;

    assign vsync_rise = vsync & ~vsync_q;
    assign de_fall    = ~de & de_q;
    assign trig       = vsync_rise | (de_fall & (y_q < 10'(V_ADDR - 1)));
    assign trig_line  = vsync_rise ? 10'd0 : y_q + 10'd1;
    assign busy_int   = (state_q != IDLE);
    assign start      = (state_q == IDLE) & (trig | pend_q);
    assign start_line = trig ? trig_line : pend_line_q;
    assign base       = AW'(line_base(FB_BASE, {22'd0, line_q}, WPL));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            y_q         <= 10'd0;
            run_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_line_q <= 10'd0;
            line_q      <= 10'd0;
            issue_q     <= 8'd0;
            underrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync;
            de_q       <= de;
            run_q      <= 1'b1;
            underrun_q <= trig & busy_int;
            if (de) begin
                y_q <= Y;
            end
            // Only one trigger is remembered while busy; a later one replaces it.
            if (start) begin
                line_q <= start_line;
                pend_q <= 1'b0;
            end else if (trig) begin
                pend_q      <= 1'b1;
                pend_line_q <= trig_line;
            end
            if (start) begin
                issue_q <= 8'd0;
            end else if (rd_gnt) begin
                issue_q <= issue_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig || pend_q) begin
                    state_d = FETCH;
                end else if (wr_req && run_q) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                    wr_gnt    = mem_gnt;
                end
            end
            FETCH: begin
                if (outstanding != OW'(MAX_OUT)) begin
                    mem_req  = 1'b1;
                    mem_addr = base + AW'(issue_q);
                    rd_gnt   = mem_gnt;
                    if (mem_gnt && (issue_q == 8'(WPL - 1))) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((outstanding == '0) && (ret_cnt == 8'(WPL))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    vga_fetch_outq #(
        .MAX_OUT (MAX_OUT),
        .DW      (DW),
        .OW      (OW)
    ) u_outq (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .clr         (start),
        .rd_gnt      (rd_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .bank        (line_q[0]),
        .outstanding (outstanding),
        .ret_cnt     (ret_cnt),
        .lb_we       (lb_we),
        .lb_bank     (lb_bank),
        .lb_waddr    (lb_waddr),
        .lb_wdata    (lb_wdata)
    );

    assign busy     = busy_int;
    assign underrun = underrun_q;

`ifdef VGA_FETCH_STATS_EN
    logic [15:0] su_q, sw_q, su_out_q, sw_out_q;

    // Running counts are published and restarted at each frame start.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            su_q     <= 16'd0;
            sw_q     <= 16'd0;
            su_out_q <= 16'd0;
            sw_out_q <= 16'd0;
        end else if (vsync_rise) begin
            su_out_q <= su_q;
            sw_out_q <= sw_q;
            su_q     <= 16'd0;
            sw_q     <= 16'd0;
        end else begin
            if (underrun_q && (su_q != 16'hFFFF)) begin
                su_q <= su_q + 16'd1;
            end
            if (wr_req && !wr_gnt && (sw_q != 16'hFFFF)) begin
                sw_q <= sw_q + 16'd1;
            end
        end
    end

    assign stat_underrun = su_out_q;
    assign stat_wr_stall = sw_out_q;
`endif

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Scoreboard bench for vga_fetch_ctrl: a memory model answers reads in order and a
// monitor checks every read address, line-buffer write and writer grant against queues.
module tb_vga_fetch_ctrl;

    localparam int unsigned TB_WPL  = 160;
    localparam int unsigned TB_MAXO = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        de = 1'b0, vsync = 1'b0;
    logic [9:0]  Y = 10'd0;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        lb_we, lb_bank;
    logic [7:0]  lb_waddr;
    logic [31:0] lb_wdata;
    logic        wr_req = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_gnt, busy, underrun;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0] stat_underrun, stat_wr_stall;
`endif

    vga_fetch_ctrl u_dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .de         (de),
        .vsync      (vsync),
        .Y          (Y),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .lb_we      (lb_we),
        .lb_bank    (lb_bank),
        .lb_waddr   (lb_waddr),
        .lb_wdata   (lb_wdata),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .busy       (busy),
        .underrun   (underrun)
`ifdef VGA_FETCH_STATS_EN
        ,
        .stat_underrun (stat_underrun),
        .stat_wr_stall (stat_wr_stall)
`endif
    );

    always #5 pclk = ~pclk;

    typedef struct { int unsigned due; logic [31:0] data; } ret_t;
    typedef struct { logic bank; logic [7:0] waddr; logic [31:0] data; } lbe_t;
    typedef struct { logic [17:0] addr; logic [31:0] data; } wre_t;

    ret_t        ret_q[$];
    logic [17:0] exp_addr_q[$];
    lbe_t        exp_lb_q[$];
    wre_t        exp_wr_q[$];

    int checks = 0, errors = 0;
    int rd_grants = 0, lb_cnt = 0, und_cnt = 0, out_m = 0, max_seen = 0;
    int unsigned cyc = 0, lat = 2;
    bit gnt_off = 1'b0, gnt_rand = 1'b0;
    logic [31:0] salt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return ({14'd0, a} * 32'h9E3779B1) ^ salt;
    endfunction

    // Reference: a fetch of line n reads n*WPL .. n*WPL+WPL-1 into bank n%2.
    task automatic push_line(input int line);
        for (int i = 0; i < int'(TB_WPL); i++) begin
            logic [17:0] a;
            lbe_t e;
            a = 18'(line * int'(TB_WPL) + i);
            exp_addr_q.push_back(a);
            e.bank  = 1'(line % 2);
            e.waddr = 8'(i);
            e.data  = mem_word(a);
            exp_lb_q.push_back(e);
        end
    endtask

    // Memory controller: in-order reads returned lat cycles after the grant.
    initial begin : mem_model
        bit g, took;
        logic [17:0] a;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge pclk);
            g    = rst_n && mem_req && mem_gnt && !mem_we;
            a    = mem_addr;
            took = mem_rvalid;
            @(posedge pclk);
            #1;
            cyc++;
            if (took && ret_q.size() != 0) ret_q.delete(0);
            if (g) ret_q.push_back('{cyc + lat - 1, mem_word(a)});
            if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ret_q[0].data;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            mem_gnt = gnt_off ? 1'b0 : (gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    always @(negedge pclk) begin : monitor
        if (!rst_n) begin
            out_m = 0;
        end else begin
            bit rv, g;
            rv = mem_rvalid && (out_m != 0);
            g  = mem_req && mem_gnt && !mem_we;
            chk("lb_we_gate", lb_we, rv);
            if (g) begin
                rd_grants++;
                chk("read_below_limit", (out_m < int'(TB_MAXO)), 1'b1);
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_read", mem_addr, '1);
                end else begin
                    chk("read_addr", mem_addr, exp_addr_q.pop_front());
                end
            end
            out_m = out_m + int'(g) - int'(rv);
            if (out_m > max_seen) max_seen = out_m;
            if (lb_we) begin
                lbe_t e;
                lb_cnt++;
                if (exp_lb_q.size() == 0) begin
                    chk("unexpected_lb_we", {lb_bank, lb_waddr}, '1);
                end else begin
                    e = exp_lb_q.pop_front();
                    chk("lb_write", {lb_bank, lb_waddr, lb_wdata}, {e.bank, e.waddr, e.data});
                end
            end
            if (wr_gnt) begin
                wre_t w;
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_wr_gnt", mem_addr, '1);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("writer_access", {mem_req, mem_we, busy, mem_addr, mem_wdata},
                        {1'b1, 1'b1, 1'b0, w.addr, w.data});
                end
            end
            if (underrun) und_cnt++;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        repeat (3) tick();
        while ((busy || exp_lb_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, {busy, 32'(exp_lb_q.size())}, '0);
    endtask

    task automatic de_line(input int y);
        if (y < 479) push_line(y + 1);
        de = 1'b1;
        Y  = 10'(y);
        repeat (4) tick();
        de = 1'b0;
        Y  = 10'($urandom);
    endtask

    task automatic do_write(input logic [17:0] a, input logic [31:0] d, input int budget);
        int n = 0;
        exp_wr_q.push_back('{a, d});
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge pclk);
        while (!wr_gnt && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk("write_granted", wr_gnt, 1'b1);
        tick();
        wr_req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, und0, rg0, lb0, ya, yb;
        salt = $urandom;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {mem_req, mem_we, lb_we, lb_bank, wr_gnt, busy, underrun, lb_waddr}, '0);
        chk("reset_data", {mem_addr, mem_wdata}, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Frame start: line 0, bank 0, fixed latency, busy must clear promptly.
        lat = 2;
        push_line(0);
        vsync = 1'b1;
        n = 0;
        while (n < 300 && (n < 2 || busy)) begin
            tick();
            n++;
            if (n == 2) vsync = 1'b0;
        end
        chk("fetch_done_within_165", (n <= 165), 1'b1);
        wait_idle("line0_complete", 50);

        de_line(10);
        wait_idle("line11_complete", 400);

        rg0 = rd_grants;
        de_line(479);
        repeat (30) tick();
        chk("no_fetch_after_last_line", {busy, 32'(rd_grants - rg0)}, '0);

        // Long latency saturates the outstanding window; then a 20-cycle grant stall.
        lat = 6;
        max_seen = 0;
        de_line(int'($urandom_range(0, 478)));
        repeat (40) tick();
        gnt_off = 1'b1;
        repeat (20) tick();
        gnt_off = 1'b0;
        wait_idle("stall_line_complete", 600);
        chk("max_outstanding", max_seen, TB_MAXO);

        // Writer held across a fetch is served only after the fetch drains.
        lat = 3;
        de_line(int'($urandom_range(0, 478)));
        do_write(18'($urandom), $urandom, 600);
        chk("write_after_drain", {busy, 32'(exp_lb_q.size())}, '0);

        gnt_rand = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_write(18'($urandom), $urandom, 50);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Second trigger mid-fetch: underrun, then both lines in order.
        lat = int'($urandom_range(1, 7));
        und0 = und_cnt;
        ya = int'($urandom_range(0, 478));
        yb = int'($urandom_range(0, 478));
        de_line(ya);
        repeat (30) tick();
        de_line(yb);
        wait_idle("underrun_both_lines", 1200);
        chk("underrun_count", und_cnt - und0, 1);

        for (int i = 0; i < 2; i++) begin
            lat = int'($urandom_range(1, 7));
            de_line(int'($urandom_range(0, 478)));
            wait_idle("random_line", 1000);
        end
        gnt_rand = 1'b0;

        // Reset in the middle of a fetch abandons it; late returns are dropped.
        lat = 4;
        rg0 = rd_grants;
        de_line(int'($urandom_range(0, 478)));
        n = 0;
        while ((rd_grants - rg0) < 80 && n < 300) begin
            tick();
            n++;
        end
        chk("reached_80_grants", ((rd_grants - rg0) >= 80), 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midfetch_reset_ctrl",
            {mem_req, mem_we, lb_we, lb_bank, wr_gnt, busy, underrun, lb_waddr}, '0);
        chk("midfetch_reset_data", {mem_addr, mem_wdata}, '0);
        chk("midfetch_reset_lbdata", lb_wdata, '0);
        exp_addr_q.delete();
        exp_lb_q.delete();
        lb0 = lb_cnt;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("late_rvalid_ignored", lb_cnt - lb0, 0);

        lat = 2;
        push_line(0);
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        wait_idle("recovery_line0", 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
